// File: rtl/attack_anim_sequencer_pkg.sv
// Shared battle package: pixel/coordinate widths, frame-count sizing, the
// attack animation state encoding and the pixel bus payload.
package attack_anim_sequencer_pkg;

    localparam int unsigned X_W                = 9;
    localparam int unsigned Y_W                = 8;
    localparam int unsigned COLOUR_W           = 3;
    localparam int unsigned FRAME_CNT_W        = 6;
    localparam int unsigned NUM_FRAMES_DEFAULT = 50;
    localparam int unsigned NUM_FRAMES_MAX     = 63;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ERASE      = 3'd1,
        STEP       = 3'd2,
        DRAW       = 3'd3,
        WAIT_FRAME = 3'd4,
        FINISH     = 3'd5
    } anim_state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // States in which a frame tick must be remembered rather than acted on.
    function automatic logic is_frame_active(input anim_state_t s);
        return (s == ERASE) || (s == STEP) || (s == DRAW);
    endfunction

endpackage

// File: rtl/anim_frame_tracker.sv
// Frame bookkeeping for the attack animation: completed-frame counter and
// the pending frame-tick flag.
//   clock, reset_all      : clock, async active-low reset
//   clear                 : start of a new run (count and pending cleared)
//   frame_done            : one frame's sprite draw finished
//   pulse_in, pulse_armed : frame tick and "tick must be remembered" qualifier
//   pending_clear         : tick consumed (leaving WAIT_FRAME)
//   frame_count           : completed frames, saturates at NUM_FRAMES
//   pending               : a tick arrived while the frame was being rendered
//   last_frame_c          : frame_count has reached NUM_FRAMES
module anim_frame_tracker
    import attack_anim_sequencer_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = NUM_FRAMES_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_all,
    input  logic                   clear,
    input  logic                   frame_done,
    input  logic                   pulse_in,
    input  logic                   pulse_armed,
    input  logic                   pending_clear,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   pending,
    output logic                   last_frame_c
);

    assign last_frame_c = (frame_count == FRAME_CNT_W'(NUM_FRAMES));

    // Counter saturates at NUM_FRAMES so it can never wrap.
    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            frame_count <= '0;
        end else if (clear) begin
            frame_count <= '0;
        end else if (frame_done && !last_frame_c) begin
            frame_count <= frame_count + FRAME_CNT_W'(1);
        end
    end

    // Any number of ticks during rendering collapse into a single pending flag.
    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            pending <= 1'b0;
        end else if (clear || pending_clear) begin
            pending <= 1'b0;
        end else if (pulse_in && pulse_armed) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/attack_anim_sequencer.sv
// Attack animation sequencer: per frame, erase the sprite, advance its
// position, redraw it, then wait for the frame tick; repeats NUM_FRAMES times.
//   clock, reset_all                   : clock, async active-low reset
//   start                              : run request, honoured only in IDLE
//   frame_pulse                        : frame timer tick
//   erase_done / draw_done             : drawer completion strobes
//   erase_x/y/colour, draw_x/y/colour  : drawer pixel streams
//   enable_erase / enable_draw / step  : drawer and motion controls
//   vga_x/y/colour, plot               : muxed pixel to VGA (combinational)
//   busy, done, frame_count            : status
module attack_anim_sequencer
    import attack_anim_sequencer_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = NUM_FRAMES_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_all,
    input  logic                   start,
    input  logic                   frame_pulse,
    input  logic                   erase_done,
    input  logic                   draw_done,
    input  logic [X_W-1:0]         erase_x,
    input  logic [Y_W-1:0]         erase_y,
    input  logic [COLOUR_W-1:0]    erase_colour,
    input  logic [X_W-1:0]         draw_x,
    input  logic [Y_W-1:0]         draw_y,
    input  logic [COLOUR_W-1:0]    draw_colour,
    output logic                   enable_erase,
    output logic                   enable_draw,
    output logic                   step,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COLOUR_W-1:0]    vga_colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    anim_state_t state;
    anim_state_t state_next;
    logic        start_accept;
    logic        frame_done;
    logic        wait_exit;
    logic        pending;
    logic        last_frame_c;
    pixel_t      pixel;

    anim_frame_tracker #(
        .NUM_FRAMES (NUM_FRAMES)
    ) u_tracker (
        .clock         (clock),
        .reset_all     (reset_all),
        .clear         (start_accept),
        .frame_done    (frame_done),
        .pulse_in      (frame_pulse),
        .pulse_armed   (is_frame_active(state)),
        .pending_clear (wait_exit),
        .frame_count   (frame_count),
        .pending       (pending),
        .last_frame_c  (last_frame_c)
    );

    // State register; status/control outputs are registered from the next
    // state so they line up exactly with the state they describe.
    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            state        <= IDLE;
            enable_erase <= 1'b0;
            enable_draw  <= 1'b0;
            step         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            enable_erase <= (state_next == ERASE);
            enable_draw  <= (state_next == DRAW);
            step         <= (state_next == STEP);
            busy         <= (state_next != IDLE);
            done         <= (state_next == FINISH);
        end
    end

    // Next-state logic and the event strobes into the frame tracker.
    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        frame_done   = 1'b0;
        wait_exit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = ERASE;
                    start_accept = 1'b1;
                end
            end
            ERASE: begin
                if (erase_done) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                state_next = DRAW;
            end
            DRAW: begin
                if (draw_done) begin
                    state_next = WAIT_FRAME;
                    frame_done = 1'b1;
                end
            end
            WAIT_FRAME: begin
                if (frame_pulse || pending) begin
                    wait_exit  = 1'b1;
                    state_next = last_frame_c ? FINISH : ERASE;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Zero-latency pixel mux: drawer pixels pass straight through to VGA.
    always_comb begin
        pixel = '0;
        plot  = 1'b0;
        case (state)
            ERASE: begin
                pixel.x      = erase_x;
                pixel.y      = erase_y;
                pixel.colour = erase_colour;
                plot         = 1'b1;
            end
            DRAW: begin
                pixel.x      = draw_x;
                pixel.y      = draw_y;
                pixel.colour = draw_colour;
                plot         = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign vga_x      = pixel.x;
    assign vga_y      = pixel.y;
    assign vga_colour = pixel.colour;

endmodule

// File: tb/tb_attack_anim_sequencer.sv
// Self-checking bench for attack_anim_sequencer. A timeline model builds the
// expected per-cycle phase and frame count from drawer latencies and the
// frame-tick schedule; every cycle the DUT outputs are compared against it.
module tb_attack_anim_sequencer;

    typedef struct packed {
        logic       ee;
        logic       ed;
        logic       st;
        logic       plot;
        logic       busy;
        logic       done;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic [5:0] fc;
    } obs_t;

    localparam int P_I = 0, P_E = 1, P_S = 2, P_D = 3, P_W = 4, P_F = 5;

    logic       clock;
    logic       reset_all, start, frame_pulse, erase_done, draw_done;
    logic [8:0] erase_x, draw_x;
    logic [7:0] erase_y, draw_y;
    logic [2:0] erase_colour, draw_colour;

    logic       ee3, ed3, st3, pl3, bz3, dn3;
    logic [8:0] vx3;
    logic [7:0] vy3;
    logic [2:0] vc3;
    logic [5:0] fc3;
    logic       ee1, ed1, st1, pl1, bz1, dn1;
    logic [8:0] vx1;
    logic [7:0] vy1;
    logic [2:0] vc1;
    logic [5:0] fc1;

    int  vec, miss, cyc, sel, e_lat, d_lat, e_age, d_age, per, ph, last_fc;
    bit  use_list, stray, start_req, start_in_draw, draw_in_erase, fixed_pix;
    bit  pulse_set[int];
    int  exp_phase[$];
    int  exp_fc[$];

    attack_anim_sequencer #(.NUM_FRAMES(3)) u_dut3 (
        .clock(clock), .reset_all(reset_all), .start(start), .frame_pulse(frame_pulse),
        .erase_done(erase_done), .draw_done(draw_done),
        .erase_x(erase_x), .erase_y(erase_y), .erase_colour(erase_colour),
        .draw_x(draw_x), .draw_y(draw_y), .draw_colour(draw_colour),
        .enable_erase(ee3), .enable_draw(ed3), .step(st3),
        .vga_x(vx3), .vga_y(vy3), .vga_colour(vc3), .plot(pl3),
        .busy(bz3), .done(dn3), .frame_count(fc3)
    );

    attack_anim_sequencer #(.NUM_FRAMES(1)) u_dut1 (
        .clock(clock), .reset_all(reset_all), .start(start), .frame_pulse(frame_pulse),
        .erase_done(erase_done), .draw_done(draw_done),
        .erase_x(erase_x), .erase_y(erase_y), .erase_colour(erase_colour),
        .draw_x(draw_x), .draw_y(draw_y), .draw_colour(draw_colour),
        .enable_erase(ee1), .enable_draw(ed1), .step(st1),
        .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1), .plot(pl1),
        .busy(bz1), .done(dn1), .frame_count(fc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t obs_of(input int which);
        obs_t o;
        if (which == 1) begin
            o.ee = ee1; o.ed = ed1; o.st = st1; o.plot = pl1; o.busy = bz1; o.done = dn1;
            o.x = vx1; o.y = vy1; o.c = vc1; o.fc = fc1;
        end else begin
            o.ee = ee3; o.ed = ed3; o.st = st3; o.plot = pl3; o.busy = bz3; o.done = dn3;
            o.x = vx3; o.y = vy3; o.c = vc3; o.fc = fc3;
        end
        return o;
    endfunction

    function automatic bit pulse_at(input int c);
        if (use_list) return pulse_set.exists(c);
        return (per > 0) && ((c % per) == ph);
    endfunction

    task automatic push(input int p, input int fc, input int count);
        for (int i = 0; i < count; i++) begin
            exp_phase.push_back(p);
            exp_fc.push_back(fc);
        end
    endtask

    // Expected timeline for a run whose start request is driven in cycle s.
    task automatic build_model(input int n, input int prev_fc, input int s,
                               input int el, input int dl);
        int  t, w, c;
        bit  pend;
        exp_phase.delete();
        exp_fc.delete();
        push(P_I, prev_fc, 1);
        t = s + 1;
        for (int f = 1; f <= n; f++) begin
            push(P_E, f - 1, el);
            push(P_S, f - 1, 1);
            push(P_D, f - 1, dl);
            w = t + el + 1 + dl;
            pend = 1'b0;
            for (int q = t; q < w; q++) if (pulse_at(q)) pend = 1'b1;
            c = w;
            if (!pend) while (!pulse_at(c) && (c < w + 5000)) c++;
            push(P_W, f, c - w + 1);
            t = c + 1;
        end
        push(P_F, n, 1);
        push(P_I, n, 3);
    endtask

    function automatic obs_t expect_at(input int k);
        obs_t e;
        e = '0;
        e.fc = 6'(exp_fc[k]);
        case (exp_phase[k])
            P_E: begin e.ee = 1; e.busy = 1; e.plot = 1; e.x = erase_x; e.y = erase_y; e.c = erase_colour; end
            P_S: begin e.st = 1; e.busy = 1; end
            P_D: begin e.ed = 1; e.busy = 1; e.plot = 1; e.x = draw_x; e.y = draw_y; e.c = draw_colour; end
            P_W: e.busy = 1;
            P_F: begin e.busy = 1; e.done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock of stimulus: drawers and frame timer react to the DUT's
    // current enables; outputs are sampled on the falling edge.
    task automatic step_cycle(output obs_t o);
        obs_t cur;
        cur = obs_of(sel);
        e_age = cur.ee ? e_age + 1 : 0;
        d_age = cur.ed ? d_age + 1 : 0;
        erase_done  = cur.ee ? (e_age >= e_lat) : (stray && ($urandom_range(0, 2) == 0));
        draw_done   = cur.ed ? (d_age >= d_lat)
                             : ((stray && ($urandom_range(0, 2) == 0)) || (draw_in_erase && cur.ee));
        frame_pulse = pulse_at(cyc);
        start = start_req || (stray && cur.busy && ($urandom_range(0, 2) == 0))
                          || (start_in_draw && cur.ed);
        if (fixed_pix) begin
            erase_x = 9'd100; erase_y = 8'd120; erase_colour = 3'b111;
            draw_x = 9'd75; draw_y = 8'd33; draw_colour = 3'b101;
        end else begin
            erase_x = 9'($urandom); erase_y = 8'($urandom); erase_colour = 3'($urandom);
            draw_x = 9'($urandom); draw_y = 8'($urandom); draw_colour = 3'($urandom);
        end
        @(negedge clock);
        o = obs_of(sel);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        obs_t o;
        reset_all = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        o = obs_of(3); vec++;
        if (o !== '0) begin miss++; $display("FAIL reset_n3 got=%h exp=0", o); end
        o = obs_of(1); vec++;
        if (o !== '0) begin miss++; $display("FAIL reset_n1 got=%h exp=0", o); end
        #2 reset_all = 1'b1;
        @(posedge clock);
        #1;
        o = obs_of(3); vec++;
        if (o !== '0) begin miss++; $display("FAIL post_reset_n3 got=%h exp=0", o); end
        o = obs_of(1); vec++;
        if (o !== '0) begin miss++; $display("FAIL post_reset_n1 got=%h exp=0", o); end
    endtask

    task automatic test_basic_run();
        obs_t o, e;
        int   steps, dones, prev;
        int   fcs[$];
        sel = 3; e_lat = 4; d_lat = 6; use_list = 0; per = 20; ph = 0;
        build_model(3, last_fc, cyc, e_lat, d_lat);
        steps = 0; dones = 0; prev = last_fc;
        start_req = 1;
        for (int k = 0; k < exp_phase.size(); k++) begin
            step_cycle(o);
            start_req = 0;
            e = expect_at(k); vec++;
            if (o !== e) begin miss++; $display("FAIL basic k=%0d got=%h exp=%h", k, o, e); end
            steps += int'(o.st); dones += int'(o.done);
            if (int'(o.fc) != prev) begin fcs.push_back(int'(o.fc)); prev = int'(o.fc); end
        end
        vec++;
        if (steps != 3) begin miss++; $display("FAIL basic_steps got=%0d exp=3", steps); end
        vec++;
        if (dones != 1) begin miss++; $display("FAIL basic_done got=%0d exp=1", dones); end
        vec++;
        if (fcs.size() != 3 || fcs[0] != 1 || fcs[1] != 2 || fcs[2] != 3) begin
            miss++; $display("FAIL basic_fc_seq got=%p exp=1,2,3", fcs);
        end
        vec++;
        if (o.busy !== 1'b0) begin miss++; $display("FAIL basic_busy_after got=%b exp=0", o.busy); end
        last_fc = 3;
    endtask

    task automatic test_pixel_mux();
        obs_t o, e;
        bit   seen_e, seen_d, seen_w;
        sel = 3; e_lat = 2; d_lat = 2; use_list = 0; per = 10; ph = 3; fixed_pix = 1;
        build_model(3, last_fc, cyc, e_lat, d_lat);
        seen_e = 0; seen_d = 0; seen_w = 0;
        start_req = 1;
        for (int k = 0; k < exp_phase.size(); k++) begin
            step_cycle(o);
            start_req = 0;
            e = expect_at(k); vec++;
            if (o !== e) begin miss++; $display("FAIL pixmux k=%0d got=%h exp=%h", k, o, e); end
            if (!seen_e && o.ee) begin
                seen_e = 1; vec++;
                if ({o.plot, o.x, o.y, o.c} !== {1'b1, 9'd100, 8'd120, 3'b111}) begin
                    miss++; $display("FAIL pix_erase got=%0d/%0d/%0d plot=%b exp=100/120/7 plot=1", o.x, o.y, o.c, o.plot);
                end
            end
            if (!seen_d && o.ed) begin
                seen_d = 1; vec++;
                if (o.x !== 9'd75) begin miss++; $display("FAIL pix_draw_x got=%0d exp=75", o.x); end
            end
            if (!seen_w && o.busy && !o.ee && !o.ed && !o.st && !o.done) begin
                seen_w = 1; vec++;
                if ({o.plot, o.x, o.y, o.c} !== '0) begin
                    miss++; $display("FAIL pix_wait got=%0d/%0d/%0d plot=%b exp=0/0/0 plot=0", o.x, o.y, o.c, o.plot);
                end
            end
        end
        fixed_pix = 0;
        last_fc = 3;
    endtask

    task automatic test_pending();
        obs_t o, e;
        int   s, steps;
        sel = 3; e_lat = 2; d_lat = 5; use_list = 1;
        s = cyc;
        pulse_set.delete();
        pulse_set[s + 5] = 1; pulse_set[s + 7] = 1;
        pulse_set[s + 40] = 1; pulse_set[s + 60] = 1;
        build_model(3, last_fc, s, e_lat, d_lat);
        steps = 0;
        start_req = 1;
        for (int k = 0; k < exp_phase.size(); k++) begin
            step_cycle(o);
            start_req = 0;
            e = expect_at(k); vec++;
            if (o !== e) begin miss++; $display("FAIL pending k=%0d got=%h exp=%h", k, o, e); end
            steps += int'(o.st);
            if (k == 10) begin
                vec++;
                if (!(o.ee === 1'b1 && o.fc === 6'd1)) begin
                    miss++; $display("FAIL pending_wait_one got ee=%b fc=%0d exp ee=1 fc=1", o.ee, o.fc);
                end
            end
        end
        vec++;
        if (steps != 3 || o.fc !== 6'd3) begin
            miss++; $display("FAIL pending_frames got steps=%0d fc=%0d exp 3/3", steps, o.fc);
        end
        use_list = 0;
        last_fc = 3;
    endtask

    task automatic test_start_ignored();
        obs_t o, e;
        int   steps;
        sel = 3; e_lat = 3; d_lat = 4; use_list = 0; per = 15; ph = 7; start_in_draw = 1;
        build_model(3, last_fc, cyc, e_lat, d_lat);
        steps = 0;
        start_req = 1;
        for (int k = 0; k < exp_phase.size(); k++) begin
            step_cycle(o);
            start_req = 0;
            e = expect_at(k); vec++;
            if (o !== e) begin miss++; $display("FAIL start_ign k=%0d got=%h exp=%h", k, o, e); end
            steps += int'(o.st);
        end
        vec++;
        if (steps != 3 || o.fc !== 6'd3) begin
            miss++; $display("FAIL start_ign_totals got steps=%0d fc=%0d exp 3/3", steps, o.fc);
        end
        start_in_draw = 0;
        last_fc = 3;
    endtask

    task automatic test_random();
        obs_t o, e;
        int   dones;
        sel = 3; use_list = 0;
        for (int r = 0; r < 4; r++) begin
            e_lat = $urandom_range(1, 6); d_lat = $urandom_range(1, 8);
            per = $urandom_range(3, 25); ph = $urandom_range(0, per - 1);
            build_model(3, last_fc, cyc, e_lat, d_lat);
            dones = 0;
            start_req = 1;
            for (int k = 0; k < exp_phase.size(); k++) begin
                step_cycle(o);
                start_req = 0;
                stray = 1;
                e = expect_at(k); vec++;
                if (o !== e) begin miss++; $display("FAIL random r=%0d k=%0d got=%h exp=%h", r, k, o, e); end
                dones += int'(o.done);
            end
            stray = 0;
            vec++;
            if (dones != 1) begin miss++; $display("FAIL random_done r=%0d got=%0d exp=1", r, dones); end
            last_fc = 3;
        end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        int   kr;
        sel = 3; e_lat = 3; d_lat = 3; use_list = 0; per = 6; ph = 0;
        build_model(3, last_fc, cyc, e_lat, d_lat);
        kr = 0;
        for (int k = exp_phase.size() - 1; k >= 0; k--)
            if (exp_phase[k] == P_E && exp_fc[k] == 1) kr = k;
        start_req = 1;
        for (int k = 0; k <= kr; k++) begin
            step_cycle(o);
            start_req = 0;
            e = expect_at(k); vec++;
            if (o !== e) begin miss++; $display("FAIL areset_pre k=%0d got=%h exp=%h", k, o, e); end
        end
        vec++;
        if (obs_of(3).ee !== 1'b1) begin miss++; $display("FAIL areset_in_erase got=0 exp=1"); end
        #1 reset_all = 1'b0;
        #1;
        o = obs_of(3); vec++;
        if (o !== '0) begin miss++; $display("FAIL areset_immediate got=%h exp=0", o); end
        @(posedge clock);
        #3 reset_all = 1'b1;
        @(posedge clock);
        #1;
        e_age = 0; d_age = 0;
        for (int k = 0; k < 8; k++) begin
            step_cycle(o);
            vec++;
            if (o !== '0) begin miss++; $display("FAIL areset_idle k=%0d got=%h exp=0", k, o); end
        end
        last_fc = 0;
    endtask

    task automatic test_single_frame();
        obs_t o, e;
        int   steps, dones;
        frame_pulse = 0; start = 0; erase_done = 0; draw_done = 0;
        reset_all = 1'b0;
        @(posedge clock);
        #2 reset_all = 1'b1;
        @(posedge clock);
        #1;
        e_age = 0; d_age = 0;
        sel = 1; e_lat = 4; d_lat = 3; use_list = 0; per = 9; ph = 4; draw_in_erase = 1;
        build_model(1, 0, cyc, e_lat, d_lat);
        steps = 0; dones = 0;
        start_req = 1;
        for (int k = 0; k < exp_phase.size(); k++) begin
            step_cycle(o);
            start_req = 0;
            e = expect_at(k); vec++;
            if (o !== e) begin miss++; $display("FAIL single k=%0d got=%h exp=%h", k, o, e); end
            steps += int'(o.st); dones += int'(o.done);
        end
        vec++;
        if (steps != 1 || dones != 1 || o.fc !== 6'd1) begin
            miss++; $display("FAIL single_totals got steps=%0d done=%0d fc=%0d exp 1/1/1", steps, dones, o.fc);
        end
        draw_in_erase = 0;
    endtask

    initial begin
        vec = 0; miss = 0; cyc = 0; sel = 3; last_fc = 0;
        e_lat = 1; d_lat = 1; e_age = 0; d_age = 0; per = 0; ph = 0;
        use_list = 0; stray = 0; start_req = 0; start_in_draw = 0; draw_in_erase = 0; fixed_pix = 0;
        start = 0; frame_pulse = 0; erase_done = 0; draw_done = 0;
        erase_x = '0; erase_y = '0; erase_colour = '0;
        draw_x = '0; draw_y = '0; draw_colour = '0;
        test_reset();
        test_basic_run();
        test_pixel_mux();
        test_pending();
        test_start_ignored();
        test_random();
        test_async_reset();
        test_single_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
